// File: rtl/netlist_vector_driver.sv
// netlist_vector_driver
// Sequential stimulus/response engine for combinational scheduling netlists.
// A vector accepted on the in_* stream is registered onto drv. After SETTLE
// idle cycles the netlist outputs (obs) are captured. {drv, obs} is then
// returned on the res_* stream. Only one vector is in flight at a time.
//
// Optional build macro: VECTOR_DRIVER_MISR_EN
//   When defined, adds output sig[15:0]. This is a 16-bit MISR that folds in
//   every captured obs. When undefined, there is no sig port and no MISR
//   logic.
module netlist_vector_driver #(
  parameter int NI     = 5,
  parameter int NO     = 2,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NI-1:0]    in_vec,
  output logic [NI-1:0]    drv,
  input  logic [NO-1:0]    obs,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [NI+NO-1:0] res_vec,
  output logic [15:0]      vec_count
`ifdef VECTOR_DRIVER_MISR_EN
  ,
  output logic [15:0]      sig
`endif
);

  // The settle counter is 8 bits wide, so longer settle times cannot be
  // represented.
  if (SETTLE < 0 || SETTLE > 255) begin : g_settle_range
    $error("netlist_vector_driver: SETTLE must be in 0..255");
  end

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  // Last counter value spent in SETTLE. It is unused when SETTLE is 0,
  // because acceptance then jumps straight to CAPTURE.
  localparam logic [7:0] SETTLE_LAST = 8'((SETTLE > 0) ? (SETTLE - 1) : 0);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] settle_cnt;
  logic       accept;
  logic       consume;

  // in_ready is gated by rst so that it reads low for the whole reset
  // assertion, not only after the first clock edge.
  assign in_ready = rst && (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign consume  = (state == ST_HOLD) && res_valid && res_ready;

  // Next-state selection for the IDLE/SETTLE/CAPTURE/HOLD sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (SETTLE > 0) ? ST_SETTLE : ST_CAPTURE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (consume) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Settle counter: cleared on acceptance and advanced while settling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= '0;
    end else if (accept) begin
      settle_cnt <= '0;
    end else if (state == ST_SETTLE) begin
      settle_cnt <= settle_cnt + 8'd1;
    end
  end

  // Drive register: it changes only when a new vector is accepted. Between
  // transactions it keeps the last applied vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drv <= '0;
    end else if (accept) begin
      drv <= in_vec;
    end
  end

  // Result register: it captures {drv, obs} once and then holds stable
  // until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_vec   <= '0;
      res_valid <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      res_vec   <= {drv, obs};
      res_valid <= 1'b1;
    end else if (consume) begin
      res_valid <= 1'b0;
    end
  end

  // Count of results taken by the consumer. It wraps from 16'hFFFF to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_count <= '0;
    end else if (consume) begin
      vec_count <= vec_count + 16'd1;
    end
  end

`ifdef VECTOR_DRIVER_MISR_EN
  logic        misr_fb;
  logic [15:0] misr_nxt;

  // MISR update: rotate left by one, apply the feedback taps, then fold in
  // obs (zero-extended to 16 bits).
  always_comb begin
    misr_fb  = sig[15];
    misr_nxt = {sig[14:0], misr_fb} ^ (misr_fb ? 16'h1020 : 16'h0000)
               ^ 16'(obs);
  end

  // The signature advances only on a capture. It does not depend on
  // res_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig <= '1;
    end else if (state == ST_CAPTURE) begin
      sig <= misr_nxt;
    end
  end
`endif

endmodule
